main_control_fsm: RTL and testbench
===================================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameter: STATE_W, default 4, width of the state register (minimum 4).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Op  in  6  instruction opcode field from the instruction register.
REQ-005 Zero  in  1  ALU zero flag.
REQ-006 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  out  1 each  multicycle datapath controls.
REQ-007 ALUSrcB  out  2  ALU B-operand select: 00 reg, 01 constant 4, 10 SignImm, 11 SignImm<<2.
REQ-008 ALUOp  out  2  drives ALU_Decoder ALUOp: 00 add, 01 sub, 10 use Funct.
REQ-009 PCSrc  out  2  next-PC select: 00 ALUResult, 01 ALUOut, 10 jump target.
REQ-010 PCEn  out  1  PC register enable, equal to PCWrite | (Branch & branch condition).
REQ-011 IllegalOp  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-012 Moore FSM: all outputs except PCEn are decoded from the current state only. PCEn also depends on Zero.
REQ-013 States and transitions:
- FETCH -> DECODE.
- DECODE -> MEMADR for lw 100011 or sw 101011.
- DECODE -> EXECUTE for R-type 000000.
- DECODE -> BRANCH for beq 000100.
- DECODE -> ADDIEX for addi 001000.
- DECODE -> JUMP for j 000010.
- DECODE -> FETCH for any other opcode.
- MEMADR -> MEMRD for lw; MEMADR -> MEMWR for sw.
- MEMRD -> MEMWB.
- EXECUTE -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-014 Output settings per state (signals not listed are 0):
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00, PCSrc=00.
- DECODE: ALUSrcB=11, ALUOp=00.
- MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEMWR: IorD=1, MemWrite=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch active.
- JUMP: PCWrite=1, PCSrc=10.
REQ-015 Branch condition is Zero for beq. PCEn in BRANCH = Zero.
REQ-016 Instruction latencies in cycles, counted from FETCH through the last state before re-entering FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-017 IllegalOp = 1 during the DECODE cycle when Op is unsupported, and 0 otherwise. The FSM returns to FETCH with no register or memory write.
REQ-018 Op is sampled only in DECODE and MEMADR. Op changes in other states have no effect.
REQ-019 Any unreachable state encoding transitions to FETCH on the next clock.

Reset
REQ-020 reset is sampled at the rising clk edge and forces state to FETCH.
REQ-021 While reset is high, PCWrite, PCEn, IRWrite, MemWrite, RegWrite and IllegalOp are 0. The other outputs take their FETCH values.
REQ-022 Reset asserted in any state, including mid-instruction, aborts the instruction. The first cycle after reset deasserts is FETCH.

Configuration
REQ-023 Macro MAIN_CONTROL_BNE_EN.
- Defined: opcode 000101 (bne) goes DECODE -> BRANCH, and the branch condition in BRANCH is ~Zero for bne.
- Undefined: 000101 is illegal and behaves per REQ-017.

Structure
REQ-024 A shared package holds the state encodings, opcode constants (R, LW, SW, BEQ, ADDI, J, BNE) and the ALUSrcB/ALUOp/PCSrc code constants. ALU_Decoder also uses the ALUOp constants.
REQ-025 One sub-module, main_control_outdec, holds the combinational state-to-control decode. The FSM top holds the state register, the next-state logic and the PCEn logic.

Verification
REQ-026 reset=1 for 2 cycles, then 0 -> outputs per REQ-021 during reset; first post-reset cycle shows IRWrite=1, PCWrite=1, ALUSrcB=01.
REQ-027 Op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-028 Op=000000 then Op=101011 -> EXECUTE shows ALUOp=10 with ALUWB RegDst=1; sw shows MemWrite=1 and IorD=1 in cycle 4.
REQ-029 Op=000100 with Zero=1 -> PCEn=1 and PCSrc=01 in cycle 3; repeat with Zero=0 -> PCEn=0.
REQ-030 Op=111111 -> IllegalOp=1 for exactly the DECODE cycle, next state FETCH, no write enables. Op=000101 is illegal unless MAIN_CONTROL_BNE_EN is defined; when defined, it branches on Zero=0.
REQ-031 reset asserted during MEMRD of lw -> MemWB never occurs (RegWrite stays 0), and FETCH follows reset release.

Source files
------------

// File: rtl/main_control_pkg.sv
// rtl/main_control_pkg.sv - shared encodings for the multicycle main control FSM
// State codes, opcodes and ALUSrcB/ALUOp/PCSrc select codes (ALUOp also used by ALU_Decoder).
package main_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDIEX  = 4'd8,
    S_ADDIWB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/main_control_outdec.sv
// rtl/main_control_outdec.sv - combinational state-to-control decode
// Unknown state codes decode to all controls inactive.
module main_control_outdec
  import main_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  output logic               iord_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_dst_o,
  output logic               memto_reg_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic [1:0]         pc_src_o,
  output logic               pc_write_o,
  output logic               branch_o
);

  always_comb begin
    iord_o      = 1'b0;
    mem_write_o = 1'b0;
    ir_write_o  = 1'b0;
    reg_dst_o   = 1'b0;
    memto_reg_o = 1'b0;
    reg_write_o = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = ALUSRCB_REG;
    alu_op_o    = ALUOP_ADD;
    pc_src_o    = PCSRC_ALU;
    pc_write_o  = 1'b0;
    branch_o    = 1'b0;
    case (state_i)
      STATE_W'(S_FETCH): begin
        ir_write_o  = 1'b1;
        pc_write_o  = 1'b1;
        alu_src_b_o = ALUSRCB_FOUR;
      end
      STATE_W'(S_DECODE): alu_src_b_o = ALUSRCB_IMMSH;
      STATE_W'(S_MEMADR), STATE_W'(S_ADDIEX): begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALUSRCB_IMM;
      end
      STATE_W'(S_MEMRD): iord_o = 1'b1;
      STATE_W'(S_MEMWB): begin
        reg_write_o = 1'b1;
        memto_reg_o = 1'b1;
      end
      STATE_W'(S_MEMWR): begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      STATE_W'(S_EXECUTE): begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      STATE_W'(S_ALUWB): begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      STATE_W'(S_ADDIWB): reg_write_o = 1'b1;
      STATE_W'(S_BRANCH): begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        branch_o    = 1'b1;
      end
      STATE_W'(S_JUMP): begin
        pc_write_o = 1'b1;
        pc_src_o   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle MIPS main control FSM (state, next-state, PCEn)
// Optional bne support is enabled by defining MAIN_CONTROL_BNE_EN.
module main_control_fsm
  import main_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp
);

  logic [STATE_W-1:0] state_q, state_d, dec_state;
  logic               illegal_dec;
  logic               dec_ir_write, dec_mem_write, dec_reg_write, dec_pc_write, dec_branch;
  logic               branch_cond;

`ifdef MAIN_CONTROL_BNE_EN
  logic bne_q, bne_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_W'(S_FETCH);
`ifdef MAIN_CONTROL_BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MAIN_CONTROL_BNE_EN
      bne_q   <= bne_d;
`endif
    end
  end

  // Op is only looked at in DECODE and MEMADR; the branch flavour is latched in DECODE.
  always_comb begin
    state_d     = STATE_W'(S_FETCH);
    illegal_dec = 1'b0;
`ifdef MAIN_CONTROL_BNE_EN
    bne_d       = bne_q;
`endif
    case (state_q)
      STATE_W'(S_FETCH):  state_d = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE): begin
        case (Op)
          OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
          OP_R:         state_d = STATE_W'(S_EXECUTE);
          OP_ADDI:      state_d = STATE_W'(S_ADDIEX);
          OP_J:         state_d = STATE_W'(S_JUMP);
          OP_BEQ: begin
            state_d = STATE_W'(S_BRANCH);
`ifdef MAIN_CONTROL_BNE_EN
            bne_d   = 1'b0;
`endif
          end
`ifdef MAIN_CONTROL_BNE_EN
          OP_BNE: begin
            state_d = STATE_W'(S_BRANCH);
            bne_d   = 1'b1;
          end
`endif
          default:      illegal_dec = 1'b1;
        endcase
      end
      STATE_W'(S_MEMADR):  state_d = (Op == OP_SW) ? STATE_W'(S_MEMWR) : STATE_W'(S_MEMRD);
      STATE_W'(S_MEMRD):   state_d = STATE_W'(S_MEMWB);
      STATE_W'(S_EXECUTE): state_d = STATE_W'(S_ALUWB);
      STATE_W'(S_ADDIEX):  state_d = STATE_W'(S_ADDIWB);
      default:             state_d = STATE_W'(S_FETCH);
    endcase
  end

  // While reset is high the outputs show FETCH selects with every enable held low.
  assign dec_state = reset ? STATE_W'(S_FETCH) : state_q;

  main_control_outdec #(.STATE_W(STATE_W)) u_outdec (
    .state_i     (dec_state),
    .iord_o      (IorD),
    .mem_write_o (dec_mem_write),
    .ir_write_o  (dec_ir_write),
    .reg_dst_o   (RegDst),
    .memto_reg_o (MemtoReg),
    .reg_write_o (dec_reg_write),
    .alu_src_a_o (ALUSrcA),
    .alu_src_b_o (ALUSrcB),
    .alu_op_o    (ALUOp),
    .pc_src_o    (PCSrc),
    .pc_write_o  (dec_pc_write),
    .branch_o    (dec_branch)
  );

  always_comb begin
`ifdef MAIN_CONTROL_BNE_EN
    branch_cond = bne_q ? ~Zero : Zero;
`else
    branch_cond = Zero;
`endif
    IRWrite   = dec_ir_write & ~reset;
    MemWrite  = dec_mem_write & ~reset;
    RegWrite  = dec_reg_write & ~reset;
    PCEn      = ~reset & (dec_pc_write | (dec_branch & branch_cond));
    IllegalOp = ~reset & illegal_dec;
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - scoreboard bench for main_control_fsm
// Honours MAIN_CONTROL_BNE_EN when deciding whether 000101 is legal.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, IllegalOp;
  logic [14:0] obs;

  main_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp};

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    logic [14:0] vec;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Field order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA | ALUSrcB ALUOp PCSrc | PCEn IllegalOp
  function automatic logic [14:0] exp_vec(input string st, input logic cond, input logic ill);
    logic [14:0] v;
    case (st)
      "RESET":            v = {7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
      "FETCH":            v = {7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
      "DECODE":           v = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, ill};
      "MEMADR", "ADDIEX": v = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      "MEMRD":            v = {7'b1000000, 8'b0};
      "MEMWB":            v = {7'b0000110, 8'b0};
      "MEMWR":            v = {7'b1100000, 8'b0};
      "EXECUTE":          v = {7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
      "ALUWB":            v = {7'b0001010, 8'b0};
      "ADDIWB":           v = {7'b0000010, 8'b0};
      "BRANCH":           v = {7'b0000001, 2'b00, 2'b01, 2'b01, cond, 1'b0};
      "JUMP":             v = {7'b0000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
      default:            v = 'x;
    endcase
    return v;
  endfunction

  task automatic push(input string tag, input string st, input logic [5:0] op,
                      input logic z, input logic cond, input logic ill);
    ent_t e;
    e.name = {tag, ".", st};
    e.op   = op;
    e.zero = z;
    e.vec  = exp_vec(st, cond, ill);
    sb.push_back(e);
  endtask

  // Ops outside DECODE/MEMADR are randomised to show they are ignored.
  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rz();
    return 1'($urandom);
  endfunction

  task automatic push_instr(input string tag, input logic [5:0] op, input logic z);
    push(tag, "FETCH", rop(), rz(), 1'b0, 1'b0);
    case (op)
      6'b100011: begin
        push(tag, "DECODE", op, rz(), 1'b0, 1'b0);
        push(tag, "MEMADR", op, rz(), 1'b0, 1'b0);
        push(tag, "MEMRD", rop(), rz(), 1'b0, 1'b0);
        push(tag, "MEMWB", rop(), rz(), 1'b0, 1'b0);
      end
      6'b101011: begin
        push(tag, "DECODE", op, rz(), 1'b0, 1'b0);
        push(tag, "MEMADR", op, rz(), 1'b0, 1'b0);
        push(tag, "MEMWR", rop(), rz(), 1'b0, 1'b0);
      end
      6'b000000: begin
        push(tag, "DECODE", op, rz(), 1'b0, 1'b0);
        push(tag, "EXECUTE", rop(), rz(), 1'b0, 1'b0);
        push(tag, "ALUWB", rop(), rz(), 1'b0, 1'b0);
      end
      6'b001000: begin
        push(tag, "DECODE", op, rz(), 1'b0, 1'b0);
        push(tag, "ADDIEX", rop(), rz(), 1'b0, 1'b0);
        push(tag, "ADDIWB", rop(), rz(), 1'b0, 1'b0);
      end
      6'b000100: begin
        push(tag, "DECODE", op, rz(), 1'b0, 1'b0);
        push(tag, "BRANCH", rop(), z, z, 1'b0);
      end
`ifdef MAIN_CONTROL_BNE_EN
      6'b000101: begin
        push(tag, "DECODE", op, rz(), 1'b0, 1'b0);
        push(tag, "BRANCH", rop(), z, ~z, 1'b0);
      end
`endif
      6'b000010: begin
        push(tag, "DECODE", op, rz(), 1'b0, 1'b0);
        push(tag, "JUMP", rop(), rz(), 1'b0, 1'b0);
      end
      default: push(tag, "DECODE", op, rz(), 1'b0, 1'b1);
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_vec("RESET", 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL reset.cycle%0d: got %b expected %b", i, obs, exp_vec("RESET", 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_lw();
    ent_t e;
    push_instr("lw", 6'b100011, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = 1'b0; Op = e.op; Zero = e.zero;
      #1;
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.vec);
      end
    end
  endtask

  task automatic test_rtype_sw();
    ent_t e;
    push_instr("rtype", 6'b000000, 1'b0);
    push_instr("sw", 6'b101011, 1'b1);
    push_instr("addi", 6'b001000, 1'b0);
    push_instr("j", 6'b000010, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = 1'b0; Op = e.op; Zero = e.zero;
      #1;
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.vec);
      end
    end
  endtask

  task automatic test_beq();
    ent_t e;
    push_instr("beq_taken", 6'b000100, 1'b1);
    push_instr("beq_not", 6'b000100, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = 1'b0; Op = e.op; Zero = e.zero;
      #1;
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.vec);
      end
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    push_instr("op3f", 6'b111111, 1'b0);
    push_instr("bne_z0", 6'b000101, 1'b0);
    push_instr("bne_z1", 6'b000101, 1'b1);
    push_instr("op01", 6'b000001, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = 1'b0; Op = e.op; Zero = e.zero;
      #1;
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    ent_t e;
    push("abort", "FETCH", rop(), rz(), 1'b0, 1'b0);
    push("abort", "DECODE", 6'b100011, rz(), 1'b0, 1'b0);
    push("abort", "MEMADR", 6'b100011, rz(), 1'b0, 1'b0);
    push("abort", "MEMRD", rop(), rz(), 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = 1'b0; Op = e.op; Zero = e.zero;
      #1;
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.vec);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== exp_vec("RESET", 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL abort.reset_in_memrd: got %b expected %b", obs, exp_vec("RESET", 1'b0, 1'b0));
    end
    @(negedge clk);
    Op = rop();
    #1;
    checks++;
    if (obs !== exp_vec("RESET", 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL abort.reset_held: got %b expected %b", obs, exp_vec("RESET", 1'b0, 1'b0));
    end
    push_instr("after_abort", 6'b100011, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = 1'b0; Op = e.op; Zero = e.zero;
      #1;
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    ent_t        e;
    logic [5:0]  ops [8];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
            6'b000100, 6'b000010, 6'b000101, 6'b110011};
    for (int i = 0; i < 24; i++)
      push_instr($sformatf("b2b%0d", i), ops[$urandom_range(0, 7)], rz());
    push("b2b_end", "FETCH", rop(), rz(), 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = 1'b0; Op = e.op; Zero = e.zero;
      #1;
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.vec);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_rtype_sw();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
